// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared types and constants for the display scan controller.
//   CODE_W  : width of one decoder code (5-bit -> 7-segment decoder input)
//   state_t : scan FSM states
// ---------------------------------------------------------------------------
package scan_pkg;

    localparam int unsigned CODE_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        BLANK,
        SHOW
    } state_t;

endpackage

// File: rtl/scan_timer.sv
// ---------------------------------------------------------------------------
// scan_timer
// Slot counter for the scan controller. Counts 0..SCAN_DIV-1 and wraps.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active-high
//   i_clr       in   synchronous clear (held while the scan is idle/committing)
//   o_in_blank  out  counter is inside the blanking part of the slot
//   o_blank_end out  last blanking cycle of the slot
//   o_slot_end  out  last cycle of the slot
// ---------------------------------------------------------------------------
module scan_timer #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_in_blank,
    output logic o_blank_end,
    output logic o_slot_end
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_slot_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_in_blank  = (r_cnt <  CNT_W'(BLANK_CYCLES));
    assign o_blank_end = (r_cnt == CNT_W'(BLANK_CYCLES - 1));
    assign o_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));

endmodule

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scan controller driving one shared 5-bit -> 7-segment
// decoder. Host writes land in a shadow bank that is copied to the active
// bank once per frame (COMMIT), so a frame never mixes old and new codes.
// Each digit slot starts with BLANK_CYCLES dark cycles to suppress ghosting.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active-high
//   enable      in   1 = scanning, 0 = display dark
//   wr_valid    in   host write request
//   wr_ready    out  write accepted on wr_valid & wr_ready (low only in COMMIT)
//   wr_idx      in   target digit; indices >= NUM_DIGITS are accepted and dropped
//   wr_code     in   5-bit code (bit0->b5 ... bit4->b1 of the decoder)
//   code_out    out  code to the decoder, same mapping as wr_code
//   digit_en    out  one-hot digit select, or all zero (registered)
//   frame_done  out  1-cycle pulse in the last SHOW cycle of a frame
// ---------------------------------------------------------------------------
module display_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
    input  logic [CODE_W-1:0]             wr_code,
    output logic [CODE_W-1:0]             code_out,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_done
);

    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned IDXP_W = IDX_W + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;

    logic [CODE_W-1:0]   r_shadow [NUM_DIGITS];
    logic [CODE_W-1:0]   r_active [NUM_DIGITS];

    logic [CODE_W-1:0]   r_code_out;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                r_wr_ready;

    logic                w_timer_clr;
    logic                w_in_blank;
    logic                w_blank_end;
    logic                w_slot_end;
    logic                w_last_idx;
    logic                w_wr_fire;
    logic                w_frame_end;
    logic [CODE_W-1:0]   w_next_code;

    // ---------------------------------------------------------------------
    // Slot timer: held at zero outside the scan so the first BLANK cycle
    // after COMMIT always starts the slot at count 0.
    // ---------------------------------------------------------------------
    assign w_timer_clr = !enable || (r_state == IDLE) || (r_state == COMMIT);

    scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_timer_clr),
        .o_in_blank  (w_in_blank),
        .o_blank_end (w_blank_end),
        .o_slot_end  (w_slot_end)
    );

    assign w_last_idx  = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_wr_fire   = wr_valid && r_wr_ready;
    assign w_frame_end = enable && (r_state == SHOW) && w_slot_end && w_last_idx;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_state_nxt = BLANK;
                w_idx_nxt   = '0;
            end
            BLANK: begin
                // Leaving on !w_in_blank as well keeps the FSM from sticking
                // in BLANK should the counter ever be outside the blank window.
                if (w_blank_end || !w_in_blank) begin
                    w_state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (w_slot_end) begin
                    if (w_last_idx) begin
                        w_state_nxt = COMMIT;
                    end else begin
                        w_state_nxt = BLANK;
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
        // Dropping enable abandons the frame from any state.
        if (!enable) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end
    end

    // ---------------------------------------------------------------------
    // Shadow bank: host writes. Out-of-range indices match no entry.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (w_wr_fire && ({1'b0, wr_idx} == IDXP_W'(i))) begin
                    r_shadow[i] <= wr_code;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Active bank: whole-frame snapshot of the shadow bank.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                r_active[i] <= '0;
            end
        end else if (r_state == COMMIT) begin
            r_active <= r_shadow;
        end
    end

    // The active bank only takes the shadow contents at the end of COMMIT,
    // so digit 0's code is taken straight from the shadow bank there.
    assign w_next_code = (r_state == COMMIT) ? r_shadow[0] : r_active[w_idx_nxt];

    // ---------------------------------------------------------------------
    // Output registers. All are computed from the next state so digit_en
    // changes on one edge only and drops to zero between every two digits.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code_out <= '0;
            r_digit_en <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            if ((w_state_nxt == BLANK) && (r_state != BLANK)) begin
                r_code_out <= w_next_code;
            end
            r_digit_en <= (w_state_nxt == SHOW) ? (NUM_DIGITS'(1) << w_idx_nxt) : '0;
            r_wr_ready <= (w_state_nxt != COMMIT);
        end
    end

    assign code_out   = r_code_out;
    assign digit_en   = r_digit_en;
    assign wr_ready   = r_wr_ready;
    assign frame_done = w_frame_end;

endmodule
